// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: M-stage pipeline inputs plus the req/ack memory bus for mem_access_ctrl.
interface mem_access_ctrl_if;
    logic        M_valid;
    logic [3:0]  M_icode;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [63:0] M_valP;
    logic [2:0]  M_stat;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic        m_stall;
    modport master (
        input  M_valid, M_icode, M_valE, M_valA, M_valP, M_stat, mem_ack, mem_rdata, mem_err,
        output mem_req, mem_we, mem_addr, mem_wdata, m_valM, m_stat, m_stall
    );
    modport slave (
        output M_valid, M_icode, M_valE, M_valA, M_valP, M_stat, mem_ack, mem_rdata, mem_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, m_valM, m_stat, m_stall
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: M-stage initiator running req/ack transactions to a multi-cycle data memory.
module mem_access_ctrl #(
    parameter int MEM_WORDS = 258,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 5
) (
    input logic clk,
    input logic reset,
    mem_access_ctrl_if.master bus
);
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t            state_q;
    logic              req_q, we_q, err_q;
    logic [63:0]       addr_q, wdata_q, valm_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              is_wr, is_rd, access, in_range;
    logic [63:0]       addr_d, wdata_d;
    always_comb begin
        is_wr    = bus.M_icode inside {4'h4, 4'h8, 4'hA};
        is_rd    = bus.M_icode inside {4'h5, 4'h9, 4'hB};
        addr_d   = (bus.M_icode == 4'h9 || bus.M_icode == 4'hB) ? bus.M_valA : bus.M_valE;
        wdata_d  = (bus.M_icode == 4'h8) ? bus.M_valP : bus.M_valA;
        access   = bus.M_valid & (is_wr | is_rd) & (bus.M_stat == SAOK);
        in_range = addr_d < 64'(MEM_WORDS);
    end
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.m_valM    = valm_q;
    assign bus.m_stall   = (state_q == IDLE && access) || state_q == BUSY;
    assign bus.m_stat    = (state_q == DONE) ? (err_q ? SADR : SAOK) : bus.M_stat;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            valm_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (access) begin
                    if (in_range) begin
                        req_q   <= 1'b1;
                        we_q    <= is_wr;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                BUSY: if (bus.mem_ack) begin
                    req_q   <= 1'b0;
                    valm_q  <= we_q ? valm_q : bus.mem_rdata;
                    err_q   <= bus.mem_err;
                    state_q <= DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_q   <= 1'b0;
                    err_q   <= 1'b1;
                    state_q <= DONE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed checks of mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [63:0] model_valm = '0;
    always #5 clk = ~clk;
    mem_access_ctrl_if bus ();
    mem_access_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master));

    function automatic bit is_write(input logic [3:0] ic);
        return ic == 4'h4 || ic == 4'h8 || ic == 4'hA;
    endfunction
    function automatic bit is_read(input logic [3:0] ic);
        return ic == 4'h5 || ic == 4'h9 || ic == 4'hB;
    endfunction

    task automatic idle_inputs();
        bus.M_valid = 1'b0; bus.M_icode = 4'h1; bus.M_stat = 3'd1;
        bus.M_valE = '0; bus.M_valA = '0; bus.M_valP = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
    endtask

    // One instruction through M; ack_at is the BUSY cycle (1-based) that sees mem_ack, 0 = never
    task automatic run(input string nm, input logic [3:0] ic, input logic [63:0] ve, va, vp,
                       input logic [2:0] st, input bit vld, input int ack_at, input bit err,
                       input logic [63:0] rd);
        bit          acc    = vld && (is_write(ic) || is_read(ic)) && st == 3'd1;
        logic [63:0] e_addr = is_read(ic) && ic != 4'h5 ? va : ve;
        logic [63:0] e_wd   = ic == 4'h8 ? vp : va;
        bit          ok     = acc && e_addr < 64'd258;
        bit          acked  = ok && ack_at >= 1 && ack_at <= 16;
        int          e_reqs = !ok ? 0 : (acked ? ack_at : 16);
        int          e_stl  = acc ? 1 + e_reqs : 0;
        logic [2:0]  e_stat = !acc ? st : ((!acked || err) ? 3'd3 : 3'd1);
        int          stalls = 0;
        int          reqs = 0;
        bit          done = 0;
        if (acked && is_read(ic)) model_valm = rd;
        bus.M_valid = vld; bus.M_icode = ic; bus.M_valE = ve; bus.M_valA = va; bus.M_valP = vp;
        bus.M_stat = st; bus.mem_rdata = rd; bus.mem_err = err;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (bus.m_stall) stalls++;
            if (bus.mem_req) begin
                reqs++;
                n_chk++;
                if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {is_write(ic), e_addr, e_wd}) begin
                    n_fail++;
                    $display("FAIL %s req_fields: got we=%0b addr=%h wdata=%h, need we=%0b addr=%h wdata=%h",
                             nm, bus.mem_we, bus.mem_addr, bus.mem_wdata, is_write(ic), e_addr, e_wd);
                end
            end
            bus.mem_ack = bus.mem_req && reqs == ack_at;
            if (!bus.m_stall) begin
                done = 1;
                n_chk += 4;
                if (bus.m_stat !== e_stat) begin
                    n_fail++; $display("FAIL %s m_stat: got %0d need %0d", nm, bus.m_stat, e_stat);
                end
                if (bus.m_valM !== model_valm) begin
                    n_fail++; $display("FAIL %s m_valM: got %h need %h", nm, bus.m_valM, model_valm);
                end
                if (stalls != e_stl) begin
                    n_fail++; $display("FAIL %s stall_cycles: got %0d need %0d", nm, stalls, e_stl);
                end
                if (reqs != e_reqs) begin
                    n_fail++; $display("FAIL %s req_cycles: got %0d need %0d", nm, reqs, e_reqs);
                end
            end else begin
                @(negedge clk);
                bus.mem_ack = 1'b0;
            end
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL %s stall_timeout: got stall held 40 cycles need release", nm);
        end
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.m_valM, bus.m_stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%0b we=%0b addr=%h wdata=%h valM=%h stall=%0b need all zero",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.m_valM, bus.m_stall);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run("rmmovq", 4'h4, 64'd8, 64'hAB, 64'h0, 3'd1, 1, 2, 0, 64'h0);
        run("mrmovq", 4'h5, 64'd16, 64'h0, 64'h0, 3'd1, 1, 1, 0, 64'h1234);
        run("call_257", 4'h8, 64'd257, 64'h0, 64'h40, 3'd1, 1, 1, 0, 64'h0);
        run("pushq_258", 4'hA, 64'd258, 64'h7, 64'h0, 3'd1, 1, 1, 0, 64'h0);
        run("popq_timeout", 4'hB, 64'h0, 64'd5, 64'h0, 3'd1, 1, 0, 0, 64'hDEAD);
        run("ret_sins", 4'h9, 64'h0, 64'd3, 64'h0, 3'd4, 1, 1, 0, 64'h0);
        run("addop", 4'h6, 64'd4, 64'd4, 64'h0, 3'd1, 1, 1, 0, 64'h0);
        run("halt", 4'h0, 64'h0, 64'h0, 64'h0, 3'd2, 1, 1, 0, 64'h0);
        run("bubble_rd", 4'h5, 64'd2, 64'h0, 64'h0, 3'd1, 0, 1, 0, 64'h99);
        run("ack_at_timeout", 4'h9, 64'h0, 64'd100, 64'h0, 3'd1, 1, 16, 0, 64'h5555);
        run("addr_wide", 4'h5, 64'h1_0000_0001, 64'h0, 64'h0, 3'd1, 1, 1, 0, 64'h77);
        run("wr_err_resp", 4'hA, 64'd10, 64'h3, 64'h0, 3'd1, 1, 3, 1, 64'h0);
    endtask

    task automatic test_ack_ignored();
        idle_inputs();
        bus.mem_ack = 1'b1; bus.mem_rdata = 64'hFFFF;
        @(negedge clk);
        #1;
        n_chk++;
        if ({bus.mem_req, bus.m_stall, bus.m_valM} !== {2'b00, model_valm}) begin
            n_fail++;
            $display("FAIL ack_in_idle: got req=%0b stall=%0b valM=%h need 0 0 %h",
                     bus.mem_req, bus.m_stall, bus.m_valM, model_valm);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_back_to_back_random();
        logic [3:0] ics [8] = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h6, 4'h2};
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  ic = ics[$urandom_range(0, 7)];
            logic [63:0] ve = ($urandom_range(0, 5) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 300));
            logic [63:0] va = ($urandom_range(0, 5) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 300));
            logic [2:0]  st = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            bit          wr_err = is_write(ic) && $urandom_range(0, 3) == 0;
            run($sformatf("rand%0d", i), ic, ve, va, {$urandom, $urandom}, st,
                $urandom_range(0, 7) != 0, $urandom_range(0, 18), wr_err, {$urandom, $urandom});
        end
    endtask

    task automatic test_reset_busy();
        idle_inputs();
        bus.M_valid = 1'b1; bus.M_icode = 4'h5; bus.M_valE = 64'd3;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++; $display("FAIL busy_before_reset: got req=%0b need 1", bus.mem_req);
        end
        reset = 1'b1;
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 64'hABCD;
        model_valm = '0;
        @(negedge clk);
        #1;
        n_chk += 2;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.m_valM, bus.m_stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_busy_outputs: got req=%0b we=%0b addr=%h wdata=%h valM=%h stall=%0b need all zero",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.m_valM, bus.m_stall);
        end
        if (bus.m_stat !== 3'd1) begin
            n_fail++; $display("FAIL reset_busy_stat: got %0d need 1", bus.m_stat);
        end
        idle_inputs();
        @(negedge clk);
        run("after_reset", 4'h4, 64'd1, 64'h11, 64'h0, 3'd1, 1, 1, 0, 64'h0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ack_ignored();
        test_back_to_back_random();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
